// File: rtl/dmem_port_arbiter.sv
// =============================================================================
// Module   : dmem_port_arbiter
// Brief    : Shares one data-memory port between two issue pipes at EX/MEM.
//            Conflicts are serialised pipe0-then-pipe1 with a one-cycle stall.
//            Optional: define DMEM_ARB_STATS_EN to add conflict_count output.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_OP_BITS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [MEM_OP_BITS-1:0] req0_mem_op,
    input  logic [ADDR_WIDTH-1:0]  req0_address,
    input  logic [DATA_WIDTH-1:0]  req0_wdata,
    input  logic [MEM_OP_BITS-1:0] req1_mem_op,
    input  logic [ADDR_WIDTH-1:0]  req1_address,
    input  logic [DATA_WIDTH-1:0]  req1_wdata,
    output logic [MEM_OP_BITS-1:0] ram_mem_op,
    output logic [ADDR_WIDTH-1:0]  ram_address,
    output logic [DATA_WIDTH-1:0]  ram_wdata,
    input  logic [DATA_WIDTH-1:0]  ram_rdata,
    output logic [DATA_WIDTH-1:0]  rdata0,
    output logic [DATA_WIDTH-1:0]  rdata1,
    output logic                   stall
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]            conflict_count
`endif
);

    localparam logic [MEM_OP_BITS-1:0] c_op_read  = MEM_OP_BITS'(1);
    localparam logic [MEM_OP_BITS-1:0] c_op_write = MEM_OP_BITS'(2);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_hold = 1'b1;

    logic [0:0]             r_state;
    logic [MEM_OP_BITS-1:0] r_h1_op;
    logic [ADDR_WIDTH-1:0]  r_h1_addr;
    logic [DATA_WIDTH-1:0]  r_h1_wdata;
    logic [DATA_WIDTH-1:0]  r_h0_rdata;

    logic w_act0;
    logic w_act1;
    logic w_conflict;

    // The reserved op encoding is deliberately excluded so it never wins the port.
    assign w_act0     = (req0_mem_op == c_op_read) || (req0_mem_op == c_op_write);
    assign w_act1     = (req1_mem_op == c_op_read) || (req1_mem_op == c_op_write);
    assign w_conflict = w_act0 && w_act1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_h1_op    <= '0;
            r_h1_addr  <= '0;
            r_h1_wdata <= '0;
            r_h0_rdata <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_conflict) begin
                        r_h0_rdata <= ram_rdata;
                        r_h1_op    <= req1_mem_op;
                        r_h1_addr  <= req1_address;
                        r_h1_wdata <= req1_wdata;
                        r_state    <= c_st_hold;
                    end
                end
                c_st_hold: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    always_comb begin
        ram_mem_op  = '0;
        ram_address = '0;
        ram_wdata   = '0;
        rdata0      = '0;
        rdata1      = '0;
        stall       = 1'b0;
        if (reset) begin
            if (r_state == c_st_hold) begin
                // Replay the captured pipe1 access; a flush drops it entirely.
                if (!flush) begin
                    ram_mem_op  = r_h1_op;
                    ram_address = r_h1_addr;
                    ram_wdata   = r_h1_wdata;
                end
                rdata0 = r_h0_rdata;
                rdata1 = ram_rdata;
            end else begin
                if (w_act0) begin
                    ram_mem_op  = req0_mem_op;
                    ram_address = req0_address;
                    ram_wdata   = req0_wdata;
                end else if (w_act1) begin
                    ram_mem_op  = req1_mem_op;
                    ram_address = req1_address;
                    ram_wdata   = req1_wdata;
                end
                if (w_act0 || w_act1) begin
                    rdata0 = ram_rdata;
                    rdata1 = ram_rdata;
                end
                stall = w_conflict;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_conflict_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_conflict_count <= '0;
        end else if ((r_state == c_st_idle) && w_conflict && (r_conflict_count != 16'hFFFF)) begin
            r_conflict_count <= r_conflict_count + 16'd1;
        end
    end

    assign conflict_count = reset ? r_conflict_count : 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// =============================================================================
// Module   : tb_dmem_port_arbiter
// Brief    : Scoreboard bench for dmem_port_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [1:0]  req0_mem_op, req1_mem_op;
    logic [15:0] req0_address, req1_address;
    logic [31:0] req0_wdata, req1_wdata;
    logic [1:0]  ram_mem_op;
    logic [15:0] ram_address;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] rdata0, rdata1;
    logic        stall;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_count;
`endif

    int total = 0;
    int bad   = 0;

    dmem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_OP_BITS(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req0_mem_op  (req0_mem_op),
        .req0_address (req0_address),
        .req0_wdata   (req0_wdata),
        .req1_mem_op  (req1_mem_op),
        .req1_address (req1_address),
        .req1_wdata   (req1_wdata),
        .ram_mem_op   (ram_mem_op),
        .ram_address  (ram_address),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .stall        (stall)
`ifdef DMEM_ARB_STATS_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on the rising edge.
    logic [31:0] mem [0:255];
    logic        load_mem;
    assign ram_rdata = mem[ram_address[7:0]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC000_0000 | i;
            mem[8'h10] <= 32'h0000_00AA;
            mem[8'h04] <= 32'h1111_0004;
            mem[8'h08] <= 32'h2222_0008;
            mem[8'h50] <= 32'h0000_BEEF;
            mem[8'h60] <= 32'h0000_0600;
        end else if (ram_mem_op == 2'd2) begin
            mem[ram_address[7:0]] <= ram_wdata;
        end
    end

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        stall;
        bit          chk_port;
        bit          chk_r0;
        logic [31:0] r0;
        bit          chk_r1;
        logic [31:0] r1;
    } exp_t;

    exp_t sb[$];
    int   next_id = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (ram_mem_op !== e.op) begin
                bad++;
                $display("FAIL c%0d ram_mem_op got=%0h want=%0h", e.id, ram_mem_op, e.op);
            end
            total++;
            if (stall !== e.stall) begin
                bad++;
                $display("FAIL c%0d stall got=%0b want=%0b", e.id, stall, e.stall);
            end
            if (e.chk_port) begin
                total++;
                if (ram_address !== e.addr) begin
                    bad++;
                    $display("FAIL c%0d ram_address got=%0h want=%0h", e.id, ram_address, e.addr);
                end
                total++;
                if (ram_wdata !== e.wdata) begin
                    bad++;
                    $display("FAIL c%0d ram_wdata got=%0h want=%0h", e.id, ram_wdata, e.wdata);
                end
            end
            if (e.chk_r0) begin
                total++;
                if (rdata0 !== e.r0) begin
                    bad++;
                    $display("FAIL c%0d rdata0 got=%0h want=%0h", e.id, rdata0, e.r0);
                end
            end
            if (e.chk_r1) begin
                total++;
                if (rdata1 !== e.r1) begin
                    bad++;
                    $display("FAIL c%0d rdata1 got=%0h want=%0h", e.id, rdata1, e.r1);
                end
            end
        end
    end

    task automatic drive(input logic rst_n, input logic fl,
                         input logic [1:0] op0, input logic [15:0] a0, input logic [31:0] w0,
                         input logic [1:0] op1, input logic [15:0] a1, input logic [31:0] w1);
        @(posedge clk);
        #1;
        reset = rst_n; flush = fl;
        req0_mem_op = op0; req0_address = a0; req0_wdata = w0;
        req1_mem_op = op1; req1_address = a1; req1_wdata = w1;
    endtask

    task automatic push(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic st, input bit chk_port,
                        input bit c0, input logic [31:0] r0, input bit c1, input logic [31:0] r1);
        exp_t e;
        e.id = next_id; e.op = op; e.addr = addr; e.wdata = wdata; e.stall = st;
        e.chk_port = chk_port; e.chk_r0 = c0; e.r0 = r0; e.chk_r1 = c1; e.r1 = r1;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic idle_cycle();
        drive(1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
        push(0, 16'h0, 0, 0, 0, 1, 32'h0, 1, 32'h0);
    endtask

    task automatic test_reset();
        drive(0, 0, 2'd1, 16'h10, 32'h0, 2'd2, 16'h30, 32'h1);
        @(negedge clk);
        total++; if (ram_mem_op !== 2'd0) begin bad++; $display("FAIL reset ram_mem_op got=%0h want=0", ram_mem_op); end
        total++; if (ram_address !== 16'h0) begin bad++; $display("FAIL reset ram_address got=%0h want=0", ram_address); end
        total++; if (ram_wdata !== 32'h0) begin bad++; $display("FAIL reset ram_wdata got=%0h want=0", ram_wdata); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset stall got=%0b want=0", stall); end
        total++; if (rdata0 !== 32'h0) begin bad++; $display("FAIL reset rdata0 got=%0h want=0", rdata0); end
        total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL reset rdata1 got=%0h want=0", rdata1); end
    endtask

    task automatic test_single();
        drive(1, 0, 2'd1, 16'h10, 32'h0, 2'd0, 16'h0, 32'h0);
        push(2'd1, 16'h10, 32'h0, 0, 1, 1, 32'hAA, 0, 32'h0);
        drive(1, 0, 2'd0, 16'h0, 32'h0, 2'd2, 16'h30, 32'h77);
        push(2'd2, 16'h30, 32'h77, 0, 1, 0, 32'h0, 0, 32'h0);
        drive(1, 0, 2'd0, 16'h0, 32'h0, 2'd1, 16'h30, 32'h0);
        push(2'd1, 16'h30, 32'h0, 0, 1, 0, 32'h0, 1, 32'h77);
        // Reserved op on pipe0 must neither win the port nor create a conflict.
        drive(1, 0, 2'd3, 16'h44, 32'h5, 2'd1, 16'h10, 32'h0);
        push(2'd1, 16'h10, 32'h0, 0, 1, 0, 32'h0, 1, 32'hAA);
        drive(1, 0, 2'd3, 16'h44, 32'h5, 2'd3, 16'h48, 32'h6);
        push(2'd0, 16'h0, 32'h0, 0, 0, 1, 32'h0, 1, 32'h0);
        idle_cycle();
    endtask

    task automatic test_conflict_read();
        drive(1, 0, 2'd1, 16'h4, 32'h0, 2'd1, 16'h8, 32'h0);
        push(2'd1, 16'h4, 32'h0, 1, 1, 0, 32'h0, 0, 32'h0);
        drive(1, 0, 2'd2, 16'h40, 32'hBAD0, 2'd2, 16'h41, 32'hBAD1);
        push(2'd1, 16'h8, 32'h0, 0, 1, 1, 32'h1111_0004, 1, 32'h2222_0008);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 2'd1, 16'h4, 32'h0, 2'd1, 16'h8, 32'h0);
        push(2'd1, 16'h4, 32'h0, 1, 1, 0, 32'h0, 0, 32'h0);
        drive(1, 0, 2'd1, 16'h10, 32'h0, 2'd1, 16'hC, 32'h0);
        push(2'd1, 16'h8, 32'h0, 0, 1, 1, 32'h1111_0004, 1, 32'h2222_0008);
        drive(1, 0, 2'd1, 16'h10, 32'h0, 2'd1, 16'hC, 32'h0);
        push(2'd1, 16'h10, 32'h0, 1, 1, 0, 32'h0, 0, 32'h0);
        drive(1, 0, 2'd0, 16'h0, 32'h0, 2'd0, 16'h0, 32'h0);
        push(2'd1, 16'hC, 32'h0, 0, 1, 1, 32'hAA, 1, 32'hC000_000C);
        idle_cycle();
    endtask

    task automatic test_write_read();
        drive(1, 0, 2'd2, 16'h20, 32'h55, 2'd1, 16'h20, 32'h99);
        push(2'd2, 16'h20, 32'h55, 1, 1, 0, 32'h0, 0, 32'h0);
        drive(1, 0, 2'd0, 16'h0, 32'h0, 2'd0, 16'h0, 32'h0);
        push(2'd1, 16'h20, 32'h99, 0, 1, 0, 32'h0, 1, 32'h55);
        idle_cycle();
    endtask

    task automatic test_flush();
        drive(1, 0, 2'd1, 16'h60, 32'h0, 2'd2, 16'h50, 32'hDEAD);
        push(2'd1, 16'h60, 32'h0, 1, 1, 0, 32'h0, 0, 32'h0);
        drive(1, 1, 2'd0, 16'h0, 32'h0, 2'd0, 16'h0, 32'h0);
        push(2'd0, 16'h0, 32'h0, 0, 0, 1, 32'h0000_0600, 0, 32'h0);
        drive(1, 0, 2'd1, 16'h50, 32'h0, 2'd0, 16'h0, 32'h0);
        push(2'd1, 16'h50, 32'h0, 0, 1, 1, 32'h0000_BEEF, 0, 32'h0);
        // Flush while idle must not block a pass-through access.
        drive(1, 1, 2'd0, 16'h0, 32'h0, 2'd2, 16'h70, 32'h1234);
        push(2'd2, 16'h70, 32'h1234, 0, 1, 0, 32'h0, 0, 32'h0);
        drive(1, 0, 2'd1, 16'h70, 32'h0, 2'd0, 16'h0, 32'h0);
        push(2'd1, 16'h70, 32'h0, 0, 1, 1, 32'h1234, 0, 32'h0);
        idle_cycle();
    endtask

    task automatic test_reset_in_hold();
        drive(1, 0, 2'd1, 16'h90, 32'h0, 2'd2, 16'h91, 32'hCAFE);
        push(2'd1, 16'h90, 32'h0, 1, 1, 0, 32'h0, 0, 32'h0);
        drive(0, 0, 2'd0, 16'h0, 32'h0, 2'd0, 16'h0, 32'h0);
        push(2'd0, 16'h0, 32'h0, 0, 1, 1, 32'h0, 1, 32'h0);
        drive(1, 0, 2'd1, 16'h91, 32'h0, 2'd0, 16'h0, 32'h0);
        push(2'd1, 16'h91, 32'h0, 0, 1, 1, 32'hC000_0091, 0, 32'h0);
        idle_cycle();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 2'd1, 16'h4, 32'h0, 2'd1, 16'h8, 32'h0);
            drive(1, 0, 2'd0, 16'h0, 32'h0, 2'd0, 16'h0, 32'h0);
        end
        @(negedge clk);
        total++;
        if (conflict_count !== 16'd3) begin
            bad++; $display("FAIL stats_three got=%0d want=3", conflict_count);
        end
        for (int k = 0; k < 70000; k++) begin
            drive(1, 0, 2'd1, 16'h4, 32'h0, 2'd1, 16'h8, 32'h0);
            drive(1, 0, 2'd0, 16'h0, 32'h0, 2'd0, 16'h0, 32'h0);
        end
        @(negedge clk);
        total++;
        if (conflict_count !== 16'hFFFF) begin
            bad++; $display("FAIL stats_saturate got=%0h want=ffff", conflict_count);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; flush = 0; load_mem = 1;
        req0_mem_op = 0; req0_address = 0; req0_wdata = 0;
        req1_mem_op = 0; req1_address = 0; req1_wdata = 0;
        @(posedge clk);
        #1 load_mem = 0;
        test_reset();
        test_single();
        test_conflict_read();
        test_back_to_back();
        test_write_read();
        test_flush();
        test_reset_in_hold();
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
